addr_region_check: RTL and testbench

ADDR_REGION_CHECK -- requirements
Module: addr_region_check

---
 rtl/addr_region_check_if.sv | 36 +++
 rtl/addr_region_check.sv | 119 +++++++++++
 tb/tb_addr_region_check.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/addr_region_check_if.sv
// Bus bundle for addr_region_check: region-table writes, address queries and results.
// All handshakes transfer on a rising clk edge where valid && ready; valid must hold with stable payload until then.
interface addr_region_check_if #(
  parameter int XLEN = 32
);
  logic            cfg_we;
  logic [3:0]      cfg_idx;
  logic [XLEN-1:0] cfg_left;
  logic [XLEN-1:0] cfg_right;
  logic            cfg_enable;

  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            req_ifetch;

  logic            resp_valid;
  logic            resp_ready;
  logic            resp_hit;
  logic [3:0]      resp_region;
  logic            resp_misaligned;

  logic [15:0]     fault_count;

  modport master (
    output cfg_we, cfg_idx, cfg_left, cfg_right, cfg_enable,
    output req_valid, req_addr, req_ifetch, resp_ready,
    input  req_ready, resp_valid, resp_hit, resp_region, resp_misaligned, fault_count
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_left, cfg_right, cfg_enable,
    input  req_valid, req_addr, req_ifetch, resp_ready,
    output req_ready, resp_valid, resp_hit, resp_region, resp_misaligned, fault_count
  );
endinterface

// File: rtl/addr_region_check.sv
// Programmable address-region checker: two-stage pipeline reporting region hit,
// lowest matching region index and instruction-fetch misalignment, with a saturating fault counter.
module addr_region_check #(
  parameter int XLEN    = 32,
  parameter int NREGION = 4,
  parameter int IALIGN  = 32
) (
  input  logic clk,
  input  logic reset_n,
  addr_region_check_if.slave bus
);

  logic [XLEN-1:0]    left_q  [NREGION];
  logic [XLEN-1:0]    right_q [NREGION];
  logic [NREGION-1:0] enable_q;

  logic               s1_valid;
  logic [1:0]         s1_addr_lo;
  logic               s1_ifetch;
  logic [NREGION-1:0] s1_match;

  logic [NREGION-1:0] match_vec;
  logic               s2_adv;
  logic               s1_adv;
  logic               accept;
  logic               enc_hit;
  logic [3:0]         enc_region;
  logic               enc_mis;
  logic [15:0]        fault_q;

  // S2 can take new data when empty or draining this cycle; req_ready never looks at req_valid.
  assign s2_adv          = !bus.resp_valid || bus.resp_ready;
  assign s1_adv          = s1_valid && s2_adv;
  assign bus.req_ready   = !s1_valid || s2_adv;
  assign accept          = bus.req_valid && bus.req_ready;
  assign bus.fault_count = fault_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGION; i++) begin
        left_q[i]  <= '0;
        right_q[i] <= '0;
      end
      enable_q <= '0;
    end else if (bus.cfg_we) begin
      // Indices at or above NREGION match no entry and are dropped.
      for (int i = 0; i < NREGION; i++) begin
        if (bus.cfg_idx == 4'(i)) begin
          left_q[i]   <= bus.cfg_left;
          right_q[i]  <= bus.cfg_right;
          enable_q[i] <= bus.cfg_enable;
        end
      end
    end
  end

  // Matching uses the table as it stands before any write landing on this same edge.
  always_comb begin
    match_vec = '0;
    for (int i = 0; i < NREGION; i++) begin
      match_vec[i] = enable_q[i] && (left_q[i] <= bus.req_addr) && (bus.req_addr <= right_q[i]);
    end
  end

  always_comb begin
    enc_hit    = |s1_match;
    enc_region = '0;
    enc_mis    = 1'b0;
    for (int i = NREGION - 1; i >= 0; i--) begin
      if (s1_match[i]) enc_region = 4'(i);
    end
    if (s1_ifetch) begin
      if (IALIGN == 16) enc_mis = s1_addr_lo[0];
      else              enc_mis = |s1_addr_lo;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid   <= 1'b0;
      s1_addr_lo <= '0;
      s1_ifetch  <= 1'b0;
      s1_match   <= '0;
    end else if (accept) begin
      s1_valid   <= 1'b1;
      s1_addr_lo <= bus.req_addr[1:0];
      s1_ifetch  <= bus.req_ifetch;
      s1_match   <= match_vec;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.resp_valid      <= 1'b0;
      bus.resp_hit        <= 1'b0;
      bus.resp_region     <= '0;
      bus.resp_misaligned <= 1'b0;
    end else if (s1_adv) begin
      bus.resp_valid      <= 1'b1;
      bus.resp_hit        <= enc_hit;
      bus.resp_region     <= enc_region;
      bus.resp_misaligned <= enc_mis;
    end else if (bus.resp_ready) begin
      bus.resp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fault_q <= '0;
    end else if (bus.resp_valid && bus.resp_ready &&
                 (!bus.resp_hit || bus.resp_misaligned) && (fault_q != 16'hFFFF)) begin
      fault_q <= fault_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_addr_region_check.sv
// Directed bench for addr_region_check: one IALIGN=32 and one IALIGN=16 instance driven in lockstep.
`timescale 1ns/1ps
module tb_addr_region_check;

  logic        clk;
  logic        reset_n;
  logic        cfg_we;
  logic [3:0]  cfg_idx;
  logic [31:0] cfg_left;
  logic [31:0] cfg_right;
  logic        cfg_enable;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ifetch;
  logic        resp_ready;

  int n_checks = 0;
  int n_fail   = 0;
  logic [0:0] exp_q[$];

  addr_region_check_if #(.XLEN(32)) bus32 ();
  addr_region_check_if #(.XLEN(32)) bus16 ();

  assign bus32.cfg_we = cfg_we;          assign bus16.cfg_we = cfg_we;
  assign bus32.cfg_idx = cfg_idx;        assign bus16.cfg_idx = cfg_idx;
  assign bus32.cfg_left = cfg_left;      assign bus16.cfg_left = cfg_left;
  assign bus32.cfg_right = cfg_right;    assign bus16.cfg_right = cfg_right;
  assign bus32.cfg_enable = cfg_enable;  assign bus16.cfg_enable = cfg_enable;
  assign bus32.req_valid = req_valid;    assign bus16.req_valid = req_valid;
  assign bus32.req_addr = req_addr;      assign bus16.req_addr = req_addr;
  assign bus32.req_ifetch = req_ifetch;  assign bus16.req_ifetch = req_ifetch;
  assign bus32.resp_ready = resp_ready;  assign bus16.resp_ready = resp_ready;

  addr_region_check #(.XLEN(32), .NREGION(4), .IALIGN(32)) u_dut (
    .clk(clk), .reset_n(reset_n), .bus(bus32)
  );
  addr_region_check #(.XLEN(32), .NREGION(4), .IALIGN(16)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .bus(bus16)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cfg_we = 0; cfg_idx = 0; cfg_left = 0; cfg_right = 0; cfg_enable = 0;
    req_valid = 0; req_addr = 0; req_ifetch = 0; resp_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1;
    tick();
  endtask

  // driver tasks
  task automatic cfg_write(input logic [3:0] idx, input logic [31:0] l, input logic [31:0] r, input logic en);
    cfg_we = 1; cfg_idx = idx; cfg_left = l; cfg_right = r; cfg_enable = en;
    tick();
    cfg_we = 0;
  endtask

  task automatic send_query(input logic [31:0] addr, input logic ifetch, output logic got,
                            output logic hit, output logic [3:0] region, output logic mis, output logic mis16);
    int waited;
    got = 0; hit = 0; region = 0; mis = 0; mis16 = 0;
    resp_ready = 1; req_valid = 1; req_addr = addr; req_ifetch = ifetch;
    waited = 0;
    #1;
    while (!bus32.req_ready && waited < 10) begin tick(); waited++; #1; end
    tick();
    req_valid = 0;
    waited = 0;
    while (!bus32.resp_valid && waited < 10) begin tick(); waited++; end
    if (bus32.resp_valid) begin
      got = 1; hit = bus32.resp_hit; region = bus32.resp_region;
      mis = bus32.resp_misaligned; mis16 = bus16.resp_misaligned;
    end
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    #3;
    n_checks++; if (bus32.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %0b expected 0", bus32.resp_valid); end
    n_checks++; if (bus32.resp_hit !== 1'b0) begin n_fail++; $display("FAIL rst_resp_hit: got %0b expected 0", bus32.resp_hit); end
    n_checks++; if (bus32.resp_region !== 4'd0) begin n_fail++; $display("FAIL rst_resp_region: got %0d expected 0", bus32.resp_region); end
    n_checks++; if (bus32.resp_misaligned !== 1'b0) begin n_fail++; $display("FAIL rst_resp_mis: got %0b expected 0", bus32.resp_misaligned); end
    n_checks++; if (bus32.fault_count !== 16'h0) begin n_fail++; $display("FAIL rst_fault_count: got %0h expected 0", bus32.fault_count); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1;
    #1;
    n_checks++; if (bus32.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %0b expected 1", bus32.req_ready); end
  endtask

  task automatic test_boundaries();
    logic [31:0] addrs [4];
    logic        exp_hit [4];
    do_reset();
    cfg_write(4'd0, 32'h1000, 32'h1FFF, 1'b1);
    addrs = '{32'h0FFF, 32'h1000, 32'h1FFF, 32'h2000};
    exp_hit = '{1'b0, 1'b1, 1'b1, 1'b0};
    resp_ready = 1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin req_valid = 1; req_addr = addrs[i]; end
      else req_valid = 0;
      #1;
      if (i < 4) begin
        n_checks++; if (bus32.req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %0b expected 1", i, bus32.req_ready); end
      end
      if (i < 2) begin
        n_checks++; if (bus32.resp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_latency[%0d]: resp_valid got %0b expected 0", i, bus32.resp_valid); end
      end else begin
        n_checks++; if (bus32.resp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %0b expected 1", i, bus32.resp_valid); end
        n_checks++; if (bus32.resp_hit !== exp_hit[i-2]) begin n_fail++; $display("FAIL b2b_hit[%0d]: got %0b expected %0b", i - 2, bus32.resp_hit, exp_hit[i-2]); end
        n_checks++; if (bus32.resp_region !== 4'd0) begin n_fail++; $display("FAIL b2b_region[%0d]: got %0d expected 0", i - 2, bus32.resp_region); end
      end
      tick();
    end
    n_checks++; if (bus32.resp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: resp_valid got %0b expected 0", bus32.resp_valid); end
    n_checks++; if (bus32.fault_count !== 16'd2) begin n_fail++; $display("FAIL b2b_fault_count: got %0d expected 2", bus32.fault_count); end
  endtask

  task automatic test_priority();
    logic [31:0] qa [5];
    logic        eh [5];
    logic [3:0]  er [5];
    logic got, hit, mis, mis16;
    logic [3:0] region;
    do_reset();
    cfg_write(4'd1, 32'h0, 32'hFFFF, 1'b1);
    cfg_write(4'd2, 32'h100, 32'h1FF, 1'b1);
    cfg_write(4'd3, 32'h25000, 32'h24000, 1'b1);  // inverted bounds
    cfg_write(4'd4, 32'h30000, 32'h3FFFF, 1'b1);  // index beyond the table
    cfg_write(4'd0, 32'h40000, 32'h4FFFF, 1'b0);  // disabled
    qa = '{32'h180, 32'h0, 32'h24800, 32'h30000, 32'h40000};
    eh = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    er = '{4'd1, 4'd1, 4'd0, 4'd0, 4'd0};
    for (int i = 0; i < 5; i++) begin
      send_query(qa[i], 1'b0, got, hit, region, mis, mis16);
      n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL prio_resp[%0d]: got %0b expected 1", i, got); end
      n_checks++; if (hit !== eh[i]) begin n_fail++; $display("FAIL prio_hit[%0d]: got %0b expected %0b", i, hit, eh[i]); end
      n_checks++; if (region !== er[i]) begin n_fail++; $display("FAIL prio_region[%0d]: got %0d expected %0d", i, region, er[i]); end
    end
  endtask

  task automatic test_misalign();
    logic [31:0] qa [5];
    logic        qf [5];
    logic        em32 [5];
    logic        em16 [5];
    logic [15:0] efc [5];
    logic got, hit, mis, mis16;
    logic [3:0] region;
    do_reset();
    cfg_write(4'd0, 32'h0, 32'hFFFF_FFFF, 1'b1);
    qa   = '{32'h1002, 32'h1002, 32'h1001, 32'h1000, 32'h1003};
    qf   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    em32 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    em16 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    efc  = '{16'd1, 16'd1, 16'd2, 16'd2, 16'd2};
    for (int i = 0; i < 5; i++) begin
      send_query(qa[i], qf[i], got, hit, region, mis, mis16);
      n_checks++; if (got !== 1'b1 || hit !== 1'b1) begin n_fail++; $display("FAIL mis_hit[%0d]: got resp=%0b hit=%0b expected 1 1", i, got, hit); end
      n_checks++; if (mis !== em32[i]) begin n_fail++; $display("FAIL mis_ialign32[%0d]: got %0b expected %0b", i, mis, em32[i]); end
      n_checks++; if (mis16 !== em16[i]) begin n_fail++; $display("FAIL mis_ialign16[%0d]: got %0b expected %0b", i, mis16, em16[i]); end
      n_checks++; if (bus32.fault_count !== efc[i]) begin n_fail++; $display("FAIL mis_fault_count[%0d]: got %0d expected %0d", i, bus32.fault_count, efc[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] addrs [3];
    logic        hits [3];
    logic [0:0]  exp_hit;
    int sent, received;
    do_reset();
    cfg_write(4'd0, 32'h0, 32'hFFFF, 1'b1);
    addrs = '{32'h10, 32'h20000, 32'h30};
    hits  = '{1'b1, 1'b0, 1'b1};
    exp_q.delete();
    sent = 0; received = 0;
    resp_ready = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (sent < 3) begin req_valid = 1; req_addr = addrs[sent]; end
      else req_valid = 0;
      #1;
      n_checks++; if (bus32.req_ready !== (cyc < 2)) begin n_fail++; $display("FAIL bp_req_ready[%0d]: got %0b expected %0b", cyc, bus32.req_ready, cyc < 2); end
      if (cyc >= 2) begin
        n_checks++; if (bus32.resp_valid !== 1'b1 || bus32.resp_hit !== 1'b1 || bus32.resp_region !== 4'd0)
          begin n_fail++; $display("FAIL bp_hold[%0d]: got valid=%0b hit=%0b region=%0d expected 1 1 0", cyc, bus32.resp_valid, bus32.resp_hit, bus32.resp_region); end
      end
      if (req_valid && bus32.req_ready) begin exp_q.push_back(hits[sent]); sent++; end
      tick();
    end
    resp_ready = 1;
    for (int cyc = 0; cyc < 10 && received < 3; cyc++) begin
      if (sent < 3) begin req_valid = 1; req_addr = addrs[sent]; end
      else req_valid = 0;
      #1;
      if (req_valid && bus32.req_ready) begin exp_q.push_back(hits[sent]); sent++; end
      if (bus32.resp_valid) begin
        received++;
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL bp_extra: unexpected response hit=%0b expected none", bus32.resp_hit); end
        else begin
          exp_hit = exp_q.pop_front();
          if (bus32.resp_hit !== exp_hit[0]) begin n_fail++; $display("FAIL bp_order[%0d]: hit got %0b expected %0b", received - 1, bus32.resp_hit, exp_hit[0]); end
        end
      end
      tick();
    end
    req_valid = 0;
    n_checks++; if (received != 3 || sent != 3) begin n_fail++; $display("FAIL bp_count: got sent=%0d received=%0d expected 3 3", sent, received); end
    n_checks++; if (bus32.fault_count !== 16'd1) begin n_fail++; $display("FAIL bp_fault_count: got %0d expected 1", bus32.fault_count); end
    tick();
    n_checks++; if (bus32.resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: resp_valid got %0b expected 0", bus32.resp_valid); end
  endtask

  task automatic test_table_write();
    logic got, hit, mis, mis16;
    logic [3:0] region;
    do_reset();
    cfg_write(4'd0, 32'h0, 32'hFFFF, 1'b1);
    resp_ready = 1; req_valid = 1; req_addr = 32'h1000; req_ifetch = 0;
    cfg_we = 1; cfg_idx = 0; cfg_left = 32'h0; cfg_right = 32'hFFFF; cfg_enable = 0;
    #1;
    n_checks++; if (bus32.req_ready !== 1'b1) begin n_fail++; $display("FAIL tw_ready: got %0b expected 1", bus32.req_ready); end
    tick();
    req_valid = 0; cfg_we = 0;
    tick();
    n_checks++; if (bus32.resp_valid !== 1'b1 || bus32.resp_hit !== 1'b1)
      begin n_fail++; $display("FAIL tw_same_cycle: got valid=%0b hit=%0b expected 1 1", bus32.resp_valid, bus32.resp_hit); end
    tick();
    send_query(32'h1000, 1'b0, got, hit, region, mis, mis16);
    n_checks++; if (got !== 1'b1 || hit !== 1'b0) begin n_fail++; $display("FAIL tw_after_disable: got resp=%0b hit=%0b expected 1 0", got, hit); end
    // Write landing while the request sits in S1.
    cfg_write(4'd0, 32'h0, 32'hFFFF, 1'b1);
    req_valid = 1; req_addr = 32'h2000;
    tick();
    req_valid = 0;
    cfg_we = 1; cfg_idx = 0; cfg_enable = 0;
    tick();
    cfg_we = 0;
    n_checks++; if (bus32.resp_valid !== 1'b1 || bus32.resp_hit !== 1'b1)
      begin n_fail++; $display("FAIL tw_in_flight: got valid=%0b hit=%0b expected 1 1", bus32.resp_valid, bus32.resp_hit); end
    tick();
  endtask

  task automatic test_saturation();
    logic got, hit, mis, mis16;
    logic [3:0] region;
    int n_resp, stalls, seen;
    do_reset();
    n_resp = 0; stalls = 0;
    resp_ready = 1; req_valid = 1; req_addr = 32'h1234;
    for (int c = 0; c < 65535; c++) begin
      if (!bus32.req_ready) stalls++;
      if (bus32.resp_valid) n_resp++;
      tick();
    end
    req_valid = 0;
    for (int c = 0; c < 4; c++) begin
      if (bus32.resp_valid) n_resp++;
      tick();
    end
    n_checks++; if (stalls != 0) begin n_fail++; $display("FAIL sat_throughput: got %0d stalls expected 0", stalls); end
    n_checks++; if (n_resp != 65535) begin n_fail++; $display("FAIL sat_resp_count: got %0d expected 65535", n_resp); end
    n_checks++; if (bus32.fault_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach: got %0h expected ffff", bus32.fault_count); end
    send_query(32'h1234, 1'b0, got, hit, region, mis, mis16);
    n_checks++; if (got !== 1'b1 || hit !== 1'b0) begin n_fail++; $display("FAIL sat_extra_miss: got resp=%0b hit=%0b expected 1 0", got, hit); end
    n_checks++; if (bus32.fault_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %0h expected ffff", bus32.fault_count); end
    // Two requests in flight, then reset.
    resp_ready = 0; req_valid = 1; req_addr = 32'h10;
    tick();
    req_addr = 32'h20;
    tick();
    req_valid = 0;
    n_checks++; if (bus32.resp_valid !== 1'b1) begin n_fail++; $display("FAIL rst_inflight_pre: resp_valid got %0b expected 1", bus32.resp_valid); end
    #2;
    reset_n = 0;
    #1;
    n_checks++; if (bus32.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_inflight_async: resp_valid got %0b expected 0", bus32.resp_valid); end
    n_checks++; if (bus32.fault_count !== 16'h0) begin n_fail++; $display("FAIL rst_inflight_fault: got %0h expected 0", bus32.fault_count); end
    @(negedge clk);
    reset_n = 1;
    resp_ready = 1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus32.resp_valid) seen++;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rst_inflight_discard: got %0d responses expected 0", seen); end
  endtask

  initial begin
    idle_inputs();
    reset_n = 0;
    test_reset();
    test_boundaries();
    test_priority();
    test_misalign();
    test_backpressure();
    test_table_write();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
